// File: rtl/distance_alarm_pkg.sv
// Shared zone encodings and buzzer timing for the distance
// alarm and the display stage.
package distance_alarm_pkg;

  typedef enum logic [1:0] {
    ZONE_SAFE = 2'd0,
    ZONE_FAR  = 2'd1,
    ZONE_MID  = 2'd2,
    ZONE_NEAR = 2'd3
  } zone_e;

  localparam int unsigned FAR_ON_MS  = 100;
  localparam int unsigned FAR_OFF_MS = 400;
  localparam int unsigned MID_ON_MS  = 100;
  localparam int unsigned MID_OFF_MS = 100;

endpackage

// File: rtl/tick_gen_ms.sv
// Free-running divider: one-clk pulse every millisecond.
module tick_gen_ms #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_o
);
  localparam int unsigned DIV =
    (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned W =
    (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/distance_alarm.sv
// Distance alarm: samples the ranger, debounces zone changes
// with exit hysteresis and drives a per-zone buzzer pattern.
module distance_alarm
  import distance_alarm_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_MS = 10,
  parameter int unsigned NEAR_CM   = 10,
  parameter int unsigned MID_CM    = 30,
  parameter int unsigned FAR_CM    = 60,
  parameter int unsigned HYST_CM   = 2,
  parameter int unsigned CONFIRM   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] distance_cm,
  input  logic        enable,
  output logic [1:0]  zone,
  output logic        buzzer,
  output logic        alarm
);
  localparam int unsigned SW =
    (SAMPLE_MS > 1) ? $clog2(SAMPLE_MS) : 1;
  localparam int unsigned CW = $clog2(CONFIRM + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_MS - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(CONFIRM);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  // 17-bit compares keep threshold + hysteresis overflow-free
  localparam logic [16:0] NEAR_T = 17'(NEAR_CM);
  localparam logic [16:0] MID_T  = 17'(MID_CM);
  localparam logic [16:0] FAR_T  = 17'(FAR_CM);
  localparam logic [16:0] NEAR_X = 17'(NEAR_CM + HYST_CM);
  localparam logic [16:0] MID_X  = 17'(MID_CM + HYST_CM);
  localparam logic [16:0] FAR_X  = 17'(FAR_CM + HYST_CM);

  localparam logic [15:0] FAR_ON  = 16'(FAR_ON_MS);
  localparam logic [15:0] FAR_PER = 16'(FAR_ON_MS + FAR_OFF_MS);
  localparam logic [15:0] MID_ON  = 16'(MID_ON_MS);
  localparam logic [15:0] MID_PER = 16'(MID_ON_MS + MID_OFF_MS);

  logic          tick;
  logic          strobe;
  logic [SW-1:0] scnt_q;
  logic [15:0]   d_q;
  logic          vld_q;
  logic [16:0]   d_ext;
  logic [16:0]   exit_t;
  zone_e         entry;
  zone_e         raw;
  zone_e         zone_q;
  zone_e         cand_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          alarm_q;
  zone_e         pz_q;
  logic [15:0]   ph_q;
  logic [15:0]   ph_eff;
  logic [15:0]   on_len;
  logic [15:0]   per_len;
  logic          chg;
  logic          buzz;

  tick_gen_ms #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick_o (tick)
  );

  assign strobe = tick && (scnt_q == S_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scnt_q <= '0;
      vld_q  <= 1'b0;
      d_q    <= '0;
    end else begin
      vld_q <= strobe;
      if (strobe) begin
        scnt_q <= '0;
        d_q    <= distance_cm;
      end else if (tick) begin
        scnt_q <= scnt_q + 1'b1;
      end
    end
  end

  assign d_ext = {1'b0, d_q};

  always_comb begin
    entry = ZONE_SAFE;
    unique case (1'b1)
      d_ext < NEAR_T:                   entry = ZONE_NEAR;
      d_ext >= NEAR_T && d_ext < MID_T: entry = ZONE_MID;
      d_ext >= MID_T && d_ext < FAR_T:  entry = ZONE_FAR;
      d_ext >= FAR_T:                   entry = ZONE_SAFE;
    endcase
  end

  always_comb begin
    exit_t = FAR_X;
    unique case (zone_q)
      ZONE_NEAR: exit_t = NEAR_X;
      ZONE_MID:  exit_t = MID_X;
      ZONE_FAR:  exit_t = FAR_X;
      ZONE_SAFE: exit_t = FAR_X;
    endcase
  end

  // Moving away from the committed zone needs the extra margin
  always_comb begin
    raw = entry;
    if (entry < zone_q && d_ext < exit_t) begin
      raw = zone_q;
    end
  end

  always_comb begin
    cnt_d = C_ONE;
    if (raw == cand_q) begin
      cnt_d = (cnt_q == C_MAX) ? C_MAX : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zone_q  <= ZONE_SAFE;
      cand_q  <= ZONE_SAFE;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else if (!enable) begin
      zone_q  <= ZONE_SAFE;
      cand_q  <= ZONE_SAFE;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else if (vld_q && d_q != 16'd0) begin
      if (raw == zone_q) begin
        cnt_q <= '0;
      end else begin
        cand_q <= raw;
        if (cnt_d == C_MAX) begin
          zone_q  <= raw;
          cnt_q   <= '0;
          alarm_q <= (raw != ZONE_SAFE);
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  end

  assign chg    = (zone_q != pz_q);
  assign ph_eff = chg ? 16'd0 : ph_q;

  always_comb begin
    on_len  = 16'd0;
    per_len = 16'd1;
    buzz    = 1'b0;
    unique case (zone_q)
      ZONE_NEAR: buzz = 1'b1;
      ZONE_FAR: begin
        on_len  = FAR_ON;
        per_len = FAR_PER;
        buzz    = ph_eff < FAR_ON;
      end
      ZONE_MID: begin
        on_len  = MID_ON;
        per_len = MID_PER;
        buzz    = ph_eff < MID_ON;
      end
      default: buzz = 1'b0;
    endcase
  end

  // A zone change restarts the pattern at the start of ON
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pz_q <= ZONE_SAFE;
      ph_q <= '0;
    end else begin
      pz_q <= zone_q;
      if (chg) begin
        ph_q <= tick ? 16'd1 : 16'd0;
      end else if (tick) begin
        ph_q <= (ph_q >= per_len - 1'b1) ? '0 : ph_q + 1'b1;
      end
    end
  end

  assign zone   = zone_q;
  assign alarm  = alarm_q;
  assign buzzer = buzz && (on_len != 16'd0 || zone_q == ZONE_NEAR);

endmodule

// File: tb/tb_distance_alarm.sv
// Bench for distance_alarm: directed scenarios plus random
// distances, checked every cycle against a behavioural model.
module tb_distance_alarm;
  localparam int CLK_HZ    = 1000;
  localparam int SAMPLE_MS = 10;
  localparam int NEAR_CM   = 10;
  localparam int MID_CM    = 30;
  localparam int FAR_CM    = 60;
  localparam int HYST_CM   = 2;
  localparam int CONFIRM   = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] distance_cm = 16'd25;
  logic [1:0]  zone;
  logic        buzzer;
  logic        alarm;

  int checks = 0;
  int failures = 0;

  distance_alarm #(
    .CLK_HZ   (CLK_HZ),
    .SAMPLE_MS(SAMPLE_MS),
    .NEAR_CM  (NEAR_CM),
    .MID_CM   (MID_CM),
    .FAR_CM   (FAR_CM),
    .HYST_CM  (HYST_CM),
    .CONFIRM  (CONFIRM)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .distance_cm(distance_cm),
    .enable     (enable),
    .zone       (zone),
    .buzzer     (buzzer),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: one millisecond per clock here
  int m_zone = 0;
  int m_cand = 0;
  int m_cnt  = 0;
  int m_cyc  = 0;
  int m_t0   = 0;
  int m_d    = 0;
  int m_r    = 0;
  bit m_pend = 0;

  function automatic int raw_of(input int d, input int z);
    int thr[4];
    int e;
    thr = '{0, FAR_CM, MID_CM, NEAR_CM};
    e = int'(d < FAR_CM) + int'(d < MID_CM) + int'(d < NEAR_CM);
    if (e < z && d < thr[z] + HYST_CM) return z;
    return e;
  endfunction

  task automatic m_set_zone(input int z);
    if (z != m_zone) m_t0 = m_cyc;
    m_zone = z;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_zone = 0;
      m_cand = 0;
      m_cnt  = 0;
      m_cyc  = 0;
      m_t0   = 0;
      m_d    = 0;
      m_pend = 0;
    end else begin
      m_cyc++;
      if (!enable) begin
        m_set_zone(0);
        m_cand = 0;
        m_cnt  = 0;
      end else if (m_pend && m_d != 0) begin
        m_r = raw_of(m_d, m_zone);
        if (m_r == m_zone) begin
          m_cnt = 0;
        end else begin
          if (m_r == m_cand) begin
            m_cnt = (m_cnt < CONFIRM) ? m_cnt + 1 : CONFIRM;
          end else begin
            m_cand = m_r;
            m_cnt  = 1;
          end
          if (m_cnt == CONFIRM) begin
            m_set_zone(m_r);
            m_cnt = 0;
          end
        end
      end
      m_pend = (m_cyc % SAMPLE_MS == 0);
      if (m_pend) m_d = int'(distance_cm);
    end
  end

  function automatic int exp_buzz();
    int ph;
    ph = m_cyc - m_t0;
    case (m_zone)
      3: return 1;
      2: return int'((ph % 200) < 100);
      1: return int'((ph % 500) < 100);
      default: return 0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("zone", int'(zone), m_zone);
      chk("buzzer", int'(buzzer), exp_buzz());
      chk("alarm", int'(alarm), int'(m_zone != 0));
    end
  end

  task automatic sample_with(input int v, input int n);
    repeat (n) begin
      distance_cm = 16'(v);
      repeat (SAMPLE_MS) @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_zone", int'(zone), 0);
    chk("rst_buzzer", int'(buzzer), 0);
    chk("rst_alarm", int'(alarm), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  int sel;
  int v;
  int hold;
  int thrs[3];

  initial begin
    thrs = '{NEAR_CM, MID_CM, FAR_CM};
    repeat (2) @(negedge clk);
    chk("reset_zone", int'(zone), 0);
    chk("reset_alarm", int'(alarm), 0);
    reset_n = 1'b1;

    // Hold 25 from reset: MID on the third strobe
    repeat (30) @(negedge clk);
    chk("r34_pre", int'(zone), 0);
    @(negedge clk);
    chk("r34_mid", int'(zone), 2);
    chk("r34_on", int'(buzzer), 1);
    repeat (100) @(negedge clk);
    chk("r34_off", int'(buzzer), 0);
    repeat (100) @(negedge clk);
    chk("r34_on2", int'(buzzer), 1);
    repeat (9) @(negedge clk);

    // Hysteresis at the MID exit edge
    sample_with(31, 5);
    chk("r35_hold", int'(zone), 2);
    sample_with(32, 3);
    chk("r35_pre", int'(zone), 2);
    @(negedge clk);
    chk("r35_far", int'(zone), 1);
    chk("r35_on", int'(buzzer), 1);
    repeat (100) @(negedge clk);
    chk("r35_off", int'(buzzer), 0);
    repeat (400) @(negedge clk);
    chk("r35_on2", int'(buzzer), 1);
    repeat (9) @(negedge clk);

    // Alternating samples never confirm, then SAFE->NEAR
    pulse_reset();
    sample_with(5, 1);
    sample_with(70, 1);
    sample_with(5, 1);
    sample_with(70, 1);
    chk("r36_safe", int'(zone), 0);
    sample_with(5, 3);
    chk("r36_pre", int'(zone), 0);
    @(negedge clk);
    chk("r36_near", int'(zone), 3);
    chk("r36_buz", int'(buzzer), 1);
    repeat (9) @(negedge clk);

    // Invalid zero sample is skipped, not counted
    sample_with(40, 1);
    sample_with(0, 1);
    sample_with(40, 1);
    sample_with(40, 1);
    chk("r37_pre", int'(zone), 3);
    @(negedge clk);
    chk("r37_far", int'(zone), 1);
    repeat (9) @(negedge clk);

    // Enable drop forces SAFE, then reconfirm
    sample_with(5, 3);
    @(negedge clk);
    chk("r38_near", int'(zone), 3);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    chk("r38_zone", int'(zone), 0);
    chk("r38_buz", int'(buzzer), 0);
    chk("r38_alarm", int'(alarm), 0);
    repeat (28) @(negedge clk);
    chk("r38_pre", int'(zone), 0);
    @(negedge clk);
    chk("r38_again", int'(zone), 3);

    // Reset in the middle of a FAR ON interval
    distance_cm = 16'd40;
    repeat (30) @(negedge clk);
    chk("r39_far", int'(zone), 1);
    repeat (20) @(negedge clk);
    chk("r39_on", int'(buzzer), 1);
    pulse_reset();
    repeat (30) @(negedge clk);
    chk("r39_pre", int'(zone), 0);
    @(negedge clk);
    chk("r39_far2", int'(zone), 1);

    // Random distances, enable drops and resets
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: v = 0;
        1: v = $urandom_range(1, 9);
        2, 3: v = thrs[$urandom_range(0, 2)] +
                  $urandom_range(0, 4) - 1;
        4: v = 16'hFFFF;
        5: v = $urandom_range(62, 65535);
        default: v = $urandom_range(1, 70);
      endcase
      distance_cm = 16'(v);
      hold = ($urandom_range(0, 2) == 0) ?
             $urandom_range(20, 60) : $urandom_range(1, 12);
      if ($urandom_range(0, 24) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        enable = 1'b1;
      end
      if ($urandom_range(0, 79) == 0) pulse_reset();
      repeat (hold) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/distance_alarm.md
DISTANCE_ALARM -- requirements
Module: distance_alarm

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SAMPLE_MS, default 10, distance sampling period in ms.
REQ-003 Parameter NEAR_CM / MID_CM / FAR_CM, defaults 10 / 30 / 60, zone entry thresholds in cm.
REQ-004 Parameter HYST_CM, default 2, exit hysteresis in cm.
REQ-005 Parameter CONFIRM, default 3, consecutive agreeing samples required to change zone.
REQ-006 clk  input  1  single system clock, all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 distance_cm  input  16  averaged distance from the upstream ultrasonic ranger, asynchronous to sampling.
REQ-009 enable  input  1  1 = alarm active; 0 = forced SAFE.
REQ-010 zone  output  2  committed zone: 0 SAFE, 1 FAR, 2 MID, 3 NEAR.
REQ-011 buzzer  output  1  active-high drive for active buzzer.
REQ-012 alarm  output  1  high whenever zone is not SAFE.

Function
REQ-013 A 1 ms tick SHALL be derived from CLK_HZ, and a sample strobe SHALL pulse for one clk every SAMPLE_MS ticks.
REQ-014 On each sample strobe distance_cm SHALL be registered; all zone decisions use only the registered value.
REQ-015 A registered value of 0 SHALL be treated as invalid (no echo): confirm counter and candidate held, zone unchanged.
REQ-016 Raw zone, moving closer: NEAR if d < NEAR_CM, else MID if d < MID_CM, else FAR if d < FAR_CM, else SAFE.
REQ-017 Raw zone, moving away from committed zone Z: leave Z only when d >= threshold(Z) + HYST_CM; d equal to threshold(Z) + HYST_CM - 1 SHALL keep Z.
REQ-018 Raw zone equal to committed zone SHALL clear the confirm counter.
REQ-019 Raw zone differing from committed zone: if equal to current candidate increment counter, else load candidate and set counter to 1.
REQ-020 When counter reaches CONFIRM, zone SHALL update to the candidate on the clk after that sample strobe, and the counter SHALL clear.
REQ-021 Zone MAY jump across several levels in one commit (e.g. SAFE to NEAR).
REQ-022 Confirm counter SHALL saturate at CONFIRM and SHALL NOT wrap.
REQ-023 Buzzer pattern per zone: SAFE constant 0; FAR 100 ms on / 400 ms off; MID 100 ms on / 100 ms off; NEAR constant 1.
REQ-024 On every zone change the pattern phase counter SHALL restart at the beginning of the ON interval.
REQ-025 enable low SHALL force zone to SAFE, buzzer 0 and clear candidate/counter within one clk; sampling continues.
REQ-026 On enable rising, behaviour SHALL resume from SAFE with CONFIRM samples required.
REQ-027 alarm SHALL equal (zone != SAFE), registered.
REQ-028 distance_cm values above FAR_CM + HYST_CM, up to 16'hFFFF, SHALL map to SAFE without overflow.

Reset
REQ-029 Asserting reset_n low SHALL immediately clear zone to SAFE, buzzer 0, alarm 0, counters, candidate and registered distance to 0.
REQ-030 Reset asserted mid-pattern or mid-confirmation SHALL discard all progress; after release the first sample strobe occurs SAMPLE_MS ms later.

Structure
REQ-031 Zone encodings and the beep on/off durations SHALL be defined as constants in a shared package used by this block and the display stage.
REQ-032 The 1 ms tick generator SHALL be a separate sub-module, tick_gen_ms, parameterised by CLK_HZ.
REQ-033 Zone FSM and buzzer pattern generator SHALL be separate always blocks inside distance_alarm.

Verification (CLK_HZ reduced to 1_000 for simulation: 1 ms = 1 clk)
REQ-034 Hold distance_cm = 25 from reset -> zone = MID exactly 3 sample strobes after release; buzzer toggles every 100 ms.
REQ-035 In MID, step to 31 for 5 samples -> zone stays MID; step to 32 -> FAR after 3 samples, buzzer 100 on / 400 off starting at ON.
REQ-036 In SAFE, alternate 5, 70, 5, 70 -> zone stays SAFE; then 5 for 3 samples -> NEAR, buzzer constant 1.
REQ-037 In NEAR, insert distance_cm = 0 between two samples of 40 and one sample of 40 -> zone commits FAR on the third valid 40, not earlier.
REQ-038 In NEAR, drop enable for 1 clk -> zone SAFE, buzzer 0 next clk; re-enable with 5 held -> NEAR again after 3 samples.
REQ-039 Assert reset_n low mid-FAR ON interval -> buzzer, alarm, zone 0 in the same cycle, no zone change before 3 strobes after release.
